ram_test_sequencer: RTL



---
 rtl/ram_test_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ram_test_sequencer.sv
// Wishbone initiator that writes a pass-dependent pattern over a RAM window, reads it back, and repeats until a mismatch.
// Optional ack timeout is built only when RAM_TEST_ACK_TIMEOUT_EN is defined.
module ram_test_sequencer #(
  parameter int          ADDRESS_WIDTH  = 8,
  parameter logic [31:0] SEED           = 32'hA5C3_0F1E,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic        pinClock,
  input  logic        pinReset,
  output logic [7:0]  pinLeds,
  output logic        pinWbCycleStrobe,
  output logic        pinWbWriteEnable,
  output logic [31:0] pinWbAddress,
  output logic [31:0] pinWbWriteData,
  input  logic [31:0] pinWbReadData,
  input  logic        pinWbAck,
  output logic        pinFailed,
  output logic        pinTimedOut,
  output logic [15:0] pinPassCount
);

  typedef enum logic [2:0] {
    ST_START, ST_WR_REQ, ST_WR_GAP, ST_WR_GAP_LAST,
    ST_RD_REQ, ST_RD_GAP, ST_PASS_DONE, ST_FAIL
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]              pass_q, pass_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic [7:0]               leds_q, leds_d;
  logic                     failed_q, failed_d;
  logic                     timed_out_q, timed_out_d;
  logic                     strobe, ack, is_last, tmo_hit;
  logic [6:0]               fail_addr7;

  function automatic logic [31:0] pattern(input logic [ADDRESS_WIDTH-1:0] a, input logic [15:0] p);
    logic [31:0] v;
    v = SEED ^ {p[7:0], 24'h0} ^ 32'(a);
    return p[0] ? ~v : v;
  endfunction

  // Strobe is the only output decoded from state, so an async reset drops it at once.
  assign strobe     = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign ack        = strobe && pinWbAck;
  assign is_last    = (addr_q == LAST_ADDR);
  assign fail_addr7 = 7'(addr_q);

`ifdef RAM_TEST_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts strobe-high cycles without ack; strobe-low cycles clear it, covering the rising edge.
  assign tmo_d   = (strobe && !pinWbAck) ? tmo_q + TMO_W'(1) : '0;
  assign tmo_hit = strobe && !pinWbAck && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pinClock or posedge pinReset) begin
    if (pinReset) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    failed_d    = failed_q;
    timed_out_d = timed_out_q;
    unique case (state_q)
      ST_START: state_d = ST_WR_REQ;
      ST_WR_REQ: begin
        if (ack) begin
          if (is_last) begin
            addr_d  = '0;
            state_d = ST_WR_GAP_LAST;
          end else begin
            addr_d  = addr_q + ADDRESS_WIDTH'(1);
            state_d = ST_WR_GAP;
          end
        end
      end
      ST_WR_GAP:      state_d = ST_WR_REQ;
      ST_WR_GAP_LAST: state_d = ST_RD_REQ;
      ST_RD_REQ: begin
        if (ack) begin
          if (pinWbReadData != pattern(addr_q, pass_q)) begin
            state_d  = ST_FAIL;
            failed_d = 1'b1;
          end else if (is_last) begin
            state_d = ST_PASS_DONE;
          end else begin
            addr_d  = addr_q + ADDRESS_WIDTH'(1);
            state_d = ST_RD_GAP;
          end
        end
      end
      ST_RD_GAP: state_d = ST_RD_REQ;
      ST_PASS_DONE: begin
        pass_d  = pass_q + 16'd1;
        addr_d  = '0;
        state_d = ST_WR_REQ;
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_START;
    endcase

    if (tmo_hit) begin
      state_d     = ST_FAIL;
      addr_d      = addr_q;
      failed_d    = 1'b1;
      timed_out_d = 1'b1;
    end

    // Registered outputs are computed from next-state values so they line up with state_q.
    we_d    = (state_d == ST_WR_REQ);
    wdata_d = pattern(addr_d, pass_d);
    if (state_d == ST_FAIL)
      leds_d = {1'b1, fail_addr7};
    else
      leds_d = {1'b0, (state_d == ST_RD_REQ) || (state_d == ST_RD_GAP), pass_d[5:0]};
  end

  always_ff @(posedge pinClock or posedge pinReset) begin
    if (pinReset) begin
      state_q     <= ST_START;
      addr_q      <= '0;
      pass_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      leds_q      <= 8'h00;
      failed_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      leds_q      <= leds_d;
      failed_q    <= failed_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign pinWbCycleStrobe = strobe;
  assign pinWbWriteEnable = we_q;
  assign pinWbAddress     = 32'(addr_q);
  assign pinWbWriteData   = wdata_q;
  assign pinLeds          = leds_q;
  assign pinFailed        = failed_q;
  assign pinTimedOut      = timed_out_q;
  assign pinPassCount     = pass_q;

endmodule
